// File: rtl/mips_cpu_pkg.sv
// Shared MIPS-I control-flow encodings and the PC sequencer state type.
package mips_cpu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {PC_RUN, PC_DSLOT, PC_HALT} pc_state_t;

  // REGIMM encodings outside these four rt values behave as no-ops.
  function automatic logic is_regimm_branch(input logic [4:0] rt_field);
    return (rt_field == RT_BLTZ)   || (rt_field == RT_BGEZ) ||
           (rt_field == RT_BLTZAL) || (rt_field == RT_BGEZAL);
  endfunction

endpackage

// File: rtl/mips_cpu_branch_cond.sv
// Combinational branch-condition evaluator for the conditional MIPS-I branches.
module mips_cpu_branch_cond
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [4:0]  i_rt_field,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic        o_taken
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = i_rs_data[31];
  assign w_rs_zero = (i_rs_data == 32'd0);

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BEQ:  o_taken = (i_rs_data == i_rt_data);
      OP_BNE:  o_taken = (i_rs_data != i_rt_data);
      OP_BLEZ: o_taken = w_rs_neg | w_rs_zero;
      OP_BGTZ: o_taken = ~w_rs_neg & ~w_rs_zero;
      OP_REGIMM: begin
        case (i_rt_field)
          RT_BLTZ, RT_BLTZAL: o_taken = w_rs_neg;
          RT_BGEZ, RT_BGEZAL: o_taken = ~w_rs_neg;
          default:            o_taken = 1'b0;
        endcase
      end
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_pc_branch_unit.sv
// PC register and control-flow sequencer: one architectural delay slot,
// link-register writes, and a halt when control transfers to HALT_ADDR.
module mips_cpu_pc_branch_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter logic [4:0]  LINK_REG     = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic        active,
  output logic        in_delay_slot,
  output logic        link_en,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        ds_branch_err
);

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_active;
  logic        r_in_dslot;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rt_field;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [25:0] w_idx;
  logic        w_is_jr;
  logic        w_is_jalr;
  logic        w_is_jump;
  logic        w_is_branch;
  logic        w_is_ctrl;
  logic        w_cond_taken;
  logic        w_taken;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_target;

  assign w_opcode   = instr[31:26];
  assign w_rt_field = instr[20:16];
  assign w_rd       = instr[15:11];
  assign w_funct    = instr[5:0];
  assign w_imm      = instr[15:0];
  assign w_idx      = instr[25:0];

  assign w_is_jr     = (w_opcode == OP_SPECIAL) && (w_funct == FUNCT_JR);
  assign w_is_jalr   = (w_opcode == OP_SPECIAL) && (w_funct == FUNCT_JALR);
  assign w_is_jump   = (w_opcode == OP_J) || (w_opcode == OP_JAL);
  assign w_is_branch = (w_opcode == OP_BEQ)  || (w_opcode == OP_BNE)  ||
                       (w_opcode == OP_BLEZ) || (w_opcode == OP_BGTZ) ||
                       ((w_opcode == OP_REGIMM) && is_regimm_branch(w_rt_field));
  assign w_is_ctrl   = w_is_branch | w_is_jump | w_is_jr | w_is_jalr;

  mips_cpu_branch_cond u_branch_cond (
    .i_opcode   (w_opcode),
    .i_rt_field (w_rt_field),
    .i_rs_data  (rs_data),
    .i_rt_data  (rt_data),
    .o_taken    (w_cond_taken)
  );

  assign w_taken = w_is_jump | w_is_jr | w_is_jalr | (w_is_branch & w_cond_taken);

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{w_imm[15]}}, w_imm, 2'b00};

  // Register jumps keep rs_data's low bits so misaligned targets surface downstream.
  always_comb begin
    w_target = w_pc_plus4 + w_br_offset;
    if (w_is_jump) begin
      w_target = {w_pc_plus4[31:28], w_idx, 2'b00};
    end else if (w_is_jr || w_is_jalr) begin
      w_target = rs_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PC_RUN;
      r_pc       <= RESET_VECTOR;
      r_target   <= 32'd0;
      r_active   <= 1'b1;
      r_in_dslot <= 1'b0;
    end else if (clk_enable && r_active) begin
      case (r_state)
        PC_RUN: begin
          r_pc <= w_pc_plus4;
          if (w_taken) begin
            r_target   <= w_target;
            r_state    <= PC_DSLOT;
            r_in_dslot <= 1'b1;
          end
        end
        // Any control instruction sitting in the slot is ignored here.
        PC_DSLOT: begin
          r_pc       <= r_target;
          r_in_dslot <= 1'b0;
          if (r_target == HALT_ADDR) begin
            r_state  <= PC_HALT;
            r_active <= 1'b0;
          end else begin
            r_state  <= PC_RUN;
          end
        end
        default: begin
          r_state <= PC_HALT;
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign active        = r_active;
  assign in_delay_slot = r_in_dslot;

  assign link_en   = (w_opcode == OP_JAL) ||
                     (w_is_jalr && (w_rd != 5'd0)) ||
                     ((w_opcode == OP_REGIMM) &&
                      ((w_rt_field == RT_BLTZAL) || (w_rt_field == RT_BGEZAL)));
  assign link_reg  = w_is_jalr ? w_rd : LINK_REG;
  assign link_data = r_pc + 32'd8;

  assign ds_branch_err = r_in_dslot & w_is_ctrl;

endmodule

// File: tb/tb_mips_cpu_pc_branch_unit.sv
// Bench for the PC/branch unit: architectural model checked every cycle plus directed literal checks.
module tb_mips_cpu_pc_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic        active;
  logic        in_delay_slot;
  logic        link_en;
  logic [4:0]  link_reg;
  logic [31:0] link_data;
  logic        ds_branch_err;

  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] RV  = 32'hBFC00000;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mips_cpu_pc_branch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .instr         (instr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .pc            (pc),
    .active        (active),
    .in_delay_slot (in_delay_slot),
    .link_en       (link_en),
    .link_reg      (link_reg),
    .link_data     (link_data),
    .ds_branch_err (ds_branch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- architectural model ----------------
  function automatic void model_branch(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] cur_pc,
                                       output bit tk, output logic [31:0] tg);
    int s;
    logic [31:0] seq;
    s   = $signed(rs);
    seq = cur_pc + 32'd4;
    tk  = 1'b0;
    tg  = seq + ({{16{ins[15]}}, ins[15:0]} * 32'd4);
    case (ins[31:26])
      6'd4: tk = (rs == rt);
      6'd5: tk = (rs != rt);
      6'd6: tk = (s <= 0);
      6'd7: tk = (s > 0);
      6'd1: begin
        if (ins[20:16] == 5'd0 || ins[20:16] == 5'd16) tk = (s < 0);
        if (ins[20:16] == 5'd1 || ins[20:16] == 5'd17) tk = (s >= 0);
      end
      6'd2, 6'd3: begin
        tk = 1'b1;
        tg = {seq[31:28], ins[25:0], 2'b00};
      end
      6'd0: if (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) begin
        tk = 1'b1;
        tg = rs;
      end
      default: tk = 1'b0;
    endcase
  endfunction

  function automatic bit model_is_ctrl(input logic [31:0] ins);
    logic [5:0] op;
    logic [4:0] rtf;
    op  = ins[31:26];
    rtf = ins[20:16];
    if (op >= 6'd2 && op <= 6'd7) return 1'b1;
    if (op == 6'd1) return (rtf == 5'd0 || rtf == 5'd1 || rtf == 5'd16 || rtf == 5'd17);
    if (op == 6'd0) return (ins[5:0] == 6'd8 || ins[5:0] == 6'd9);
    return 1'b0;
  endfunction

  function automatic bit model_link_en(input logic [31:0] ins);
    if (ins[31:26] == 6'd3) return 1'b1;
    if (ins[31:26] == 6'd1 && (ins[20:16] == 5'd16 || ins[20:16] == 5'd17)) return 1'b1;
    if (ins[31:26] == 6'd0 && ins[5:0] == 6'd9) return (ins[15:11] != 5'd0);
    return 1'b0;
  endfunction

  function automatic logic [4:0] model_link_reg(input logic [31:0] ins);
    if (ins[31:26] == 6'd0 && ins[5:0] == 6'd9) return ins[15:11];
    return 5'd31;
  endfunction

  logic [31:0] m_pc, m_target;
  bit          m_active, m_slot, m_valid;

  initial begin
    m_valid = 1'b0;
    m_pc = 32'd0; m_target = 32'd0; m_active = 1'b0; m_slot = 1'b0;
  end

  always @(posedge clk) begin
    bit          tk;
    logic [31:0] tg;
    if (reset) begin
      m_pc = RV; m_target = 32'd0; m_active = 1'b1; m_slot = 1'b0; m_valid = 1'b1;
    end else if (m_valid && clk_enable && m_active) begin
      if (m_slot) begin
        m_pc   = m_target;
        m_slot = 1'b0;
        if (m_target == 32'd0) m_active = 1'b0;
      end else begin
        model_branch(instr, rs_data, rt_data, m_pc, tk, tg);
        if (tk) begin
          m_target = tg;
          m_slot   = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("active", {31'd0, active}, {31'd0, m_active});
      chk("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, m_slot});
      chk("link_en", {31'd0, link_en}, {31'd0, model_link_en(instr)});
      chk("link_reg", {27'd0, link_reg}, {27'd0, model_link_reg(instr)});
      chk("link_data", link_data, m_pc + 32'd8);
      chk("ds_branch_err", {31'd0, ds_branch_err},
          {31'd0, (m_slot && model_is_ctrl(instr))});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input logic ce = 1'b1, input logic rst = 1'b0);
    instr = ins; rs_data = rs; rt_data = rt; clk_enable = ce; reset = rst;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(NOP, 32'd0, 32'd0, 1'b0, 1'b1);
    tick;
    drive(NOP, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] BLEZ_2 = 32'h18000002;
  localparam logic [31:0] BEQ_3  = 32'h10000003;
  localparam logic [31:0] JR     = 32'h00000008;

  logic [31:0] mix_ins [6] = '{32'h14000002, 32'h1C000002, 32'h04010002,
                               32'h04000002, 32'h04110002, 32'h04020002};
  logic [31:0] mix_rs  [6] = '{32'd5, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};

  initial begin
    drive(NOP, 32'd0, 32'd0, 1'b1, 1'b1);
    tick;
    do_reset;
    chk("rst_pc", pc, RV);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_ds", {31'd0, in_delay_slot}, 32'd0);
    $display("txn reset pc=%h", pc);

    // blez taken
    drive(BLEZ_2, 32'd0, 32'd0); tick;
    chk("blez_t_slot_pc", pc, 32'hBFC00004);
    chk("blez_t_slot_ds", {31'd0, in_delay_slot}, 32'd1);
    drive(NOP, 32'd0, 32'd0); tick;
    chk("blez_t_target", pc, 32'hBFC0000C);
    chk("blez_t_ds_clr", {31'd0, in_delay_slot}, 32'd0);
    $display("txn blez-taken pc=%h", pc);

    // blez not taken
    do_reset;
    drive(BLEZ_2, 32'd1, 32'd0); tick;
    chk("blez_nt_pc", pc, 32'hBFC00004);
    chk("blez_nt_ds", {31'd0, in_delay_slot}, 32'd0);
    drive(NOP, 32'd0, 32'd0); tick;
    chk("blez_nt_pc2", pc, 32'hBFC00008);
    $display("txn blez-not-taken pc=%h", pc);

    // bltzal taken with link
    do_reset;
    drive(32'h04100004, 32'hFFFFFFFF, 32'd0); #1;
    chk("bltzal_link_en", {31'd0, link_en}, 32'd1);
    chk("bltzal_link_reg", {27'd0, link_reg}, 32'd31);
    chk("bltzal_link_data", link_data, 32'hBFC00008);
    tick;
    chk("bltzal_ds", {31'd0, in_delay_slot}, 32'd1);
    drive(NOP, 32'd0, 32'd0); tick;
    chk("bltzal_target", pc, 32'hBFC00014);
    $display("txn bltzal pc=%h", pc);

    // jr to HALT_ADDR
    do_reset;
    repeat (4) tick;
    chk("pre_jr_pc", pc, 32'hBFC00010);
    drive(JR, 32'd0, 32'd0); tick;
    chk("jr_slot_pc", pc, 32'hBFC00014);
    chk("jr_slot_active", {31'd0, active}, 32'd1);
    drive(NOP, 32'd0, 32'd0); tick;
    chk("halt_pc", pc, 32'd0);
    chk("halt_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? 32'h08000040 : BEQ_3, 32'd7, 32'd7); tick;
    end
    chk("halt_hold_pc", pc, 32'd0);
    chk("halt_hold_active", {31'd0, active}, 32'd0);
    $display("txn jr-halt pc=%h active=%0d", pc, active);

    // stall in delay slot
    do_reset;
    drive(BEQ_3, 32'd5, 32'd5); tick;
    drive(NOP, 32'd0, 32'd0, 1'b0);
    repeat (3) tick;
    chk("stall_pc", pc, 32'hBFC00004);
    chk("stall_ds", {31'd0, in_delay_slot}, 32'd1);
    drive(NOP, 32'd0, 32'd0); tick;
    chk("stall_resume", pc, 32'hBFC00010);
    $display("txn beq-stall pc=%h", pc);

    // reset while in delay slot
    do_reset;
    drive(BEQ_3, 32'd9, 32'd9); tick;
    drive(NOP, 32'd0, 32'd0, 1'b1, 1'b1); tick;
    chk("dsrst_pc", pc, RV);
    chk("dsrst_active", {31'd0, active}, 32'd1);
    chk("dsrst_ds", {31'd0, in_delay_slot}, 32'd0);
    drive(NOP, 32'd0, 32'd0); tick;
    chk("dsrst_discard", pc, 32'hBFC00004);
    $display("txn reset-in-slot pc=%h", pc);

    // 32-bit wrap does not halt
    do_reset;
    drive(JR, 32'hFFFFFFFC, 32'd0); tick;
    drive(NOP, 32'd0, 32'd0); tick;
    chk("wrap_pre", pc, 32'hFFFFFFFC);
    tick;
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_active", {31'd0, active}, 32'd1);
    tick;
    chk("wrap_next", pc, 32'd4);
    $display("txn wrap pc=%h", pc);

    // control instruction in the delay slot
    do_reset;
    drive(BEQ_3, 32'd1, 32'd1); tick;
    drive(32'h0C000010, 32'd0, 32'd0); #1;
    chk("dserr_flag", {31'd0, ds_branch_err}, 32'd1);
    chk("dserr_link_en", {31'd0, link_en}, 32'd1);
    tick;
    chk("dserr_pc", pc, 32'hBFC00010);
    chk("dserr_ds", {31'd0, in_delay_slot}, 32'd0);
    $display("txn ds-branch pc=%h", pc);

    // jalr rd=0 / rd=5, unmasked target
    do_reset;
    drive(32'h00000009, 32'hBFC00102, 32'd0); #1;
    chk("jalr_rd0_link_en", {31'd0, link_en}, 32'd0);
    tick;
    drive(32'h00002809, 32'h00000100, 32'd0); #1;
    chk("jalr_rd5_link_reg", {27'd0, link_reg}, 32'd5);
    chk("jalr_rd5_link_en", {31'd0, link_en}, 32'd1);
    tick;
    chk("jalr_target", pc, 32'hBFC00102);
    $display("txn jalr pc=%h", pc);

    // j region target
    do_reset;
    drive(32'h08000040, 32'd0, 32'd0); tick;
    drive(NOP, 32'd0, 32'd0); tick;
    chk("j_target", pc, 32'hB0000100);
    $display("txn j pc=%h", pc);

    // remaining conditions, checked by the model each cycle
    do_reset;
    for (int i = 0; i < 6; i++) begin
      drive(mix_ins[i], mix_rs[i], 32'd5); tick;
      drive(NOP, 32'd0, 32'd0); tick;
      $display("txn mix%0d instr=%h pc=%h", i, mix_ins[i], pc);
    end
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
